// File: rtl/button_conditioner.sv
// Button front end: per-button two-flop synchroniser, debounce FSM, and registered
// level / press / release / long-press outputs for the tamagotchi controller.
module button_conditioner #(
    parameter int NUM_BTN         = 6,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int HOLD_CYCLES     = 250000000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
    localparam logic          INACTIVE  = ACTIVE_LOW;

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_chan
            logic          sync1_reg, sync2_reg;
            logic          p;
            state_t        state_reg, state_next;
            logic [DW-1:0] deb_cnt_reg, deb_cnt_next;
            logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
            logic          long_done_reg, long_done_next;
            logic          level_reg, level_next;
            logic          press_reg, press_next;
            logic          release_reg, release_next;
            logic          long_reg, long_next;

            // XOR with the idle level turns either polarity into 1 = pressed.
            assign p = sync2_reg ^ INACTIVE;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sync1_reg     <= INACTIVE;
                    sync2_reg     <= INACTIVE;
                    state_reg     <= IDLE;
                    deb_cnt_reg   <= '0;
                    hold_cnt_reg  <= '0;
                    long_done_reg <= 1'b0;
                    level_reg     <= 1'b0;
                    press_reg     <= 1'b0;
                    release_reg   <= 1'b0;
                    long_reg      <= 1'b0;
                end else begin
                    sync1_reg     <= btn_raw[gi];
                    sync2_reg     <= sync1_reg;
                    state_reg     <= state_next;
                    deb_cnt_reg   <= deb_cnt_next;
                    hold_cnt_reg  <= hold_cnt_next;
                    long_done_reg <= long_done_next;
                    level_reg     <= level_next;
                    press_reg     <= press_next;
                    release_reg   <= release_next;
                    long_reg      <= long_next;
                end
            end

            always_comb begin
                state_next     = state_reg;
                deb_cnt_next   = deb_cnt_reg;
                hold_cnt_next  = hold_cnt_reg;
                long_done_next = long_done_reg;
                press_next     = 1'b0;
                release_next   = 1'b0;
                long_next      = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (p) begin
                            state_next   = DEB_PRESS;
                            deb_cnt_next = '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (!p) begin
                            state_next = IDLE;
                        end else if (deb_cnt_reg == DEB_LAST) begin
                            state_next     = PRESSED;
                            press_next     = 1'b1;
                            hold_cnt_next  = '0;
                            long_done_next = 1'b0;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!p) begin
                            state_next   = DEB_RELEASE;
                            deb_cnt_next = '0;
                        end else begin
                            if (hold_cnt_reg != HOLD_MAX) begin
                                hold_cnt_next = hold_cnt_reg + 1'b1;
                            end
                            if (hold_cnt_reg == HOLD_LAST && !long_done_reg) begin
                                long_next      = 1'b1;
                                long_done_next = 1'b1;
                            end
                        end
                    end
                    DEB_RELEASE: begin
                        // A bounce back to pressed keeps hold_cnt and long_done intact.
                        if (p) begin
                            state_next = PRESSED;
                        end else if (deb_cnt_reg == DEB_LAST) begin
                            state_next   = IDLE;
                            release_next = 1'b1;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + 1'b1;
                        end
                    end
                    default: state_next = IDLE;
                endcase
                level_next = (state_next == PRESSED) || (state_next == DEB_RELEASE);
            end

            assign btn_level[gi]   = level_reg;
            assign btn_press[gi]   = press_reg;
            assign btn_release[gi] = release_reg;
            assign btn_long[gi]    = long_reg;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, active-low buttons.
module tb_button_conditioner;

    localparam int N = 6;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_long;

    button_conditioner #(
        .NUM_BTN(N), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10), .ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
        .btn_level(btn_level), .btn_press(btn_press),
        .btn_release(btn_release), .btn_long(btn_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int press_cnt[N], press_cyc[N], long_cnt[N], long_cyc[N];
    int rel_cnt[N], rel_cyc[N], level_cnt[N], level_first[N], level_last[N];
    int overlap[N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic clear_stats();
        for (int i = 0; i < N; i++) begin
            press_cnt[i] = 0; press_cyc[i] = -1; long_cnt[i] = 0; long_cyc[i] = -1;
            rel_cnt[i] = 0; rel_cyc[i] = -1; level_cnt[i] = 0;
            level_first[i] = -1; level_last[i] = -1; overlap[i] = 0;
        end
    endtask

    // Advance one clock and sample outputs 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (btn_press[i])   begin press_cnt[i]++; press_cyc[i] = cyc; end
            if (btn_long[i])    begin long_cnt[i]++;  long_cyc[i]  = cyc; end
            if (btn_release[i]) begin rel_cnt[i]++;   rel_cyc[i]   = cyc; end
            if (btn_press[i] && btn_long[i]) overlap[i]++;
            if (btn_level[i]) begin
                level_cnt[i]++;
                if (level_first[i] < 0) level_first[i] = cyc;
                level_last[i] = cyc;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int m, n;
    int long5_before;

    initial begin
        rst_n   = 1'b0;
        btn_raw = '0;
        clear_stats();
        run(5);
        check("rst_level",   32'(btn_level),   32'd0);
        check("rst_press",   32'(btn_press),   32'd0);
        check("rst_release", 32'(btn_release), 32'd0);
        check("rst_long",    32'(btn_long),    32'd0);

        // Release reset with every button held: all channels qualify together.
        clear_stats();
        m = cyc;
        rst_n = 1'b1;
        run(20);
        for (int i = 0; i < N; i++) begin
            check($sformatf("all_press_cnt[%0d]", i), 32'(press_cnt[i]), 32'd1);
            check($sformatf("all_press_cyc[%0d]", i), 32'(press_cyc[i]), 32'(m + 7));
        end
        btn_raw = '1;
        run(20);

        // Clean long hold on bit 0.
        clear_stats();
        m = cyc;
        btn_raw[0] = 1'b0;
        run(120);
        check("p0_press_cnt",   32'(press_cnt[0]),   32'd1);
        check("p0_press_cyc",   32'(press_cyc[0]),   32'(m + 7));
        check("p0_level_first", 32'(level_first[0]), 32'(m + 7));
        check("p0_level_cnt",   32'(level_cnt[0]),   32'd114);
        check("p0_long_cnt",    32'(long_cnt[0]),    32'd1);
        check("p0_long_cyc",    32'(long_cyc[0]),    32'(m + 17));
        check("p0_overlap",     32'(overlap[0]),     32'd0);
        btn_raw[0] = 1'b1;
        run(20);

        // Repeated 3-cycle glitches on bit 2 must be ignored.
        clear_stats();
        for (int r = 0; r < 5; r++) begin
            btn_raw[2] = 1'b0; run(3);
            btn_raw[2] = 1'b1; run(3);
        end
        run(10);
        check("g2_press",   32'(press_cnt[2]), 32'd0);
        check("g2_level",   32'(level_cnt[2]), 32'd0);
        check("g2_long",    32'(long_cnt[2]),  32'd0);
        check("g2_release", 32'(rel_cnt[2]),   32'd0);

        // Long press on bit 4, then a bouncy release.
        clear_stats();
        m = cyc;
        btn_raw[4] = 1'b0;
        run(30);
        n = cyc;
        btn_raw[4] = 1'b1; run(2);
        btn_raw[4] = 1'b0; run(1);
        btn_raw[4] = 1'b1; run(20);
        check("r4_long_cnt",   32'(long_cnt[4]),   32'd1);
        check("r4_long_cyc",   32'(long_cyc[4]),   32'(m + 17));
        check("r4_rel_cnt",    32'(rel_cnt[4]),    32'd1);
        check("r4_rel_cyc",    32'(rel_cyc[4]),    32'(n + 10));
        check("r4_level_last", 32'(level_last[4]), 32'(n + 9));
        check("r4_level_cnt",  32'(level_cnt[4]),  32'(n + 9 - (m + 7) + 1));
        check("r4_press_cnt",  32'(press_cnt[4]),  32'd1);

        // Simultaneous presses on bits 1 and 3.
        clear_stats();
        m = cyc;
        btn_raw[1] = 1'b0;
        btn_raw[3] = 1'b0;
        run(30);
        check("s1_press_cyc", 32'(press_cyc[1]), 32'(m + 7));
        check("s3_press_cyc", 32'(press_cyc[3]), 32'(m + 7));
        check("s1_long_cyc",  32'(long_cyc[1]),  32'(m + 17));
        check("s3_long_cyc",  32'(long_cyc[3]),  32'(m + 17));
        check("s_others",     32'(press_cnt[0] + press_cnt[2] + press_cnt[4] + press_cnt[5]), 32'd0);
        btn_raw[1] = 1'b1;
        btn_raw[3] = 1'b1;
        run(20);

        // Reset in the middle of the hold on bit 5 (hold_cnt = 5).
        clear_stats();
        m = cyc;
        btn_raw[5] = 1'b0;
        run(12);
        rst_n = 1'b0;
        run(3);
        check("m5_rst_level", 32'(btn_level[5]), 32'd0);
        check("m5_rst_long",  32'(long_cnt[5]),  32'd0);
        long5_before = long_cnt[5];
        n = cyc;
        rst_n = 1'b1;
        run(30);
        check("m5_press_cnt",  32'(press_cnt[5]), 32'd2);
        check("m5_press_cyc",  32'(press_cyc[5]), 32'(n + 7));
        check("m5_long_cnt",   32'(long_cnt[5] - long5_before), 32'd1);
        check("m5_long_cyc",   32'(long_cyc[5]),  32'(n + 17));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
